exec_stage: RTL
===============

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all registers.
REQ-002 reset_n  input  1  asynchronous active-low reset.
REQ-003 d_ir, d_pc, d_rs, d_rt, d_ext  input  32 each  D-stage instruction, PC, GPR[rs], GPR[rt], extended immediate (lui upper-shifted by D).
REQ-004 d_valid  input  1  D slot holds a real instruction.
REQ-005 e_clr  input  1  load a bubble into the E register this edge.
REQ-006 e_hold  input  1  freeze the E register this edge.
REQ-007 alu_op  input  2  E-stage ALU code from the E controller (ADD=0, SUB=1, OR=2, AND=3).
REQ-008 b_sel  input  1  ALU B operand: 0 = forwarded rt, 1 = E immediate.
REQ-009 fwd_rs_sel, fwd_rt_sel  input  2 each  operand source: 0 = E register, 1 = m_alu, 2 = w_data, 3 = E register.
REQ-010 w_data  input  32  W-stage write-back value for forwarding.
REQ-011 e_ir, e_pc, e_valid  output  32/32/1  current E register contents; e_ir feeds the E controller.
REQ-012 m_ir, m_pc, m_alu, m_wdata, m_valid  output  32/32/32/32/1  E/M register: instruction, PC, ALU result, store data.

Function
REQ-013 E register (ir, pc, rs, rt, ext, valid) SHALL update each rising edge; priority e_clr > e_hold > load from D.
REQ-014 e_clr SHALL load all E fields as zero (nop, valid 0) regardless of e_hold or d_valid.
REQ-015 e_hold without e_clr SHALL keep every E field unchanged.
REQ-016 Operand A SHALL be the fwd_rs_sel-selected rs value; forwarded rt SHALL be the fwd_rt_sel-selected rt value; B = b_sel ? E ext : forwarded rt.
REQ-017 ALU result SHALL be combinational from the current E register and alu_op: A+B, A-B, A|B, A&B, modulo 2^32, no overflow trap or flag.
REQ-018 E/M register SHALL load each edge: m_ir/m_pc from E, m_alu from ALU, m_wdata = forwarded rt, m_valid = e_valid.
REQ-019 When e_hold is asserted, E/M SHALL load a bubble (all zero, m_valid 0) so a held instruction is never duplicated into M.
REQ-020 When e_clr and e_hold are both asserted, E/M SHALL take the bubble and E SHALL take the nop.
REQ-021 Latency: a non-held D instruction SHALL appear on e_* one edge after capture and on m_* at the next edge.
REQ-022 Forwarding from m_alu SHALL use the value registered before the current edge, with no combinational path from m_alu into itself.
REQ-023 A bubble (ir = 0) SHALL propagate with valid 0; its ALU result is don't-care but SHALL be registered as 0 when it comes from e_clr.

Reset
REQ-024 While reset_n = 0, all E and E/M fields SHALL be 0 immediately, independent of clk.
REQ-025 Reset deassertion SHALL take effect at the first rising edge after release; an operation in flight during reset is discarded.

Structure
REQ-026 ALU opcode values, field slices and the nop word SHALL live in the shared constants file used by the controllers.
REQ-027 The ALU SHALL be one sub-module, alu (a, b, op -> result), purely combinational; registers and forwarding muxes stay in exec_stage.

Verification
REQ-028 addu: d_rs=5, d_rt=3, alu_op=0, b_sel=0 -> m_alu=8 two edges after capture, m_valid=1.
REQ-029 subu wrap: rs=0, rt=1, alu_op=1 -> m_alu=0xFFFFFFFF.
REQ-030 lui: d_ext=0x12340000, rs=0, alu_op=2, b_sel=1 -> m_alu=0x12340000; sw with rt=0xAB, ext=4, rs=0x100 -> m_alu=0x104, m_wdata=0xAB.
REQ-031 Forwarding: E rs stale=1, m_alu=7, fwd_rs_sel=1, rt=2, addu -> m_alu=9; fwd_rs_sel=2 with w_data=10 -> 12.
REQ-032 e_hold for 2 cycles then release -> e_* stable, m_valid=0 for 2 edges, the instruction reaches M exactly once; e_clr with e_hold -> e_ir=0, e_valid=0.
REQ-033 reset_n pulled low mid-cycle with valid E and M -> all outputs 0 before the next edge; first post-release edge loads D normally.

Source files
------------

// File: rtl/exec_stage_pkg.sv
// Shared execute-stage constants: ALU codes, forwarding selects, instruction
// field slices and the pipeline register layouts used by exec_stage and the controllers.
package exec_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_OR  = 2'd2,
    ALU_AND = 2'd3
  } alu_op_e;

  // Code 3 aliases the E register so an undecoded select falls back safely.
  typedef enum logic [1:0] {
    FWD_E     = 2'd0,
    FWD_M     = 2'd1,
    FWD_W     = 2'd2,
    FWD_E_ALT = 2'd3
  } fwd_sel_e;

  localparam logic [XLEN-1:0] NOP_WORD = '0;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  function automatic logic [OP_MSB-OP_LSB:0] ir_opcode(input logic [XLEN-1:0] ir);
    return ir[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [FUNCT_MSB-FUNCT_LSB:0] ir_funct(input logic [XLEN-1:0] ir);
    return ir[FUNCT_MSB:FUNCT_LSB];
  endfunction

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic [XLEN-1:0] ext;
    logic            valid;
  } e_reg_t;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] wdata;
    logic            valid;
  } m_reg_t;

endpackage

// File: rtl/exec_stage_alu.sv
// Execute-stage ALU: purely combinational add/sub/or/and, wrapping modulo 2^32.
module alu
  import exec_stage_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result
);

  // NOTE: every output of an always_comb gets a value on every path (here via
  // the default arm); a path that leaves it unassigned infers a latch.
  always_comb begin
    unique case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_OR:  result = a | b;
      ALU_AND: result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: D->E pipeline register with clear/hold, operand forwarding,
// ALU, and the E->M pipeline register that takes a bubble whenever E is held.
module exec_stage
  import exec_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] d_ir,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_rs,
  input  logic [XLEN-1:0] d_rt,
  input  logic [XLEN-1:0] d_ext,
  input  logic            d_valid,
  input  logic            e_clr,
  input  logic            e_hold,
  input  logic [1:0]      alu_op,
  input  logic            b_sel,
  input  logic [1:0]      fwd_rs_sel,
  input  logic [1:0]      fwd_rt_sel,
  input  logic [XLEN-1:0] w_data,
  output logic [XLEN-1:0] e_ir,
  output logic [XLEN-1:0] e_pc,
  output logic            e_valid,
  output logic [XLEN-1:0] m_ir,
  output logic [XLEN-1:0] m_pc,
  output logic [XLEN-1:0] m_alu,
  output logic [XLEN-1:0] m_wdata,
  output logic            m_valid
);

  e_reg_t          e_d, e_q;
  m_reg_t          m_d, m_q;
  logic [XLEN-1:0] rs_fwd, rt_fwd, op_b, alu_result;

  always_comb begin
    e_d = e_q;
    if (e_clr) begin
      e_d    = '0;
      e_d.ir = NOP_WORD;
    end else if (!e_hold) begin
      e_d.ir    = d_ir;
      e_d.pc    = d_pc;
      e_d.rs    = d_rs;
      e_d.rt    = d_rt;
      e_d.ext   = d_ext;
      e_d.valid = d_valid;
    end
  end

  // m_q.alu is the registered value, so forwarding from M never loops combinationally.
  always_comb begin
    unique case (fwd_sel_e'(fwd_rs_sel))
      FWD_M:   rs_fwd = m_q.alu;
      FWD_W:   rs_fwd = w_data;
      default: rs_fwd = e_q.rs;
    endcase
    unique case (fwd_sel_e'(fwd_rt_sel))
      FWD_M:   rt_fwd = m_q.alu;
      FWD_W:   rt_fwd = w_data;
      default: rt_fwd = e_q.rt;
    endcase
    op_b = b_sel ? e_q.ext : rt_fwd;
  end

  alu u_alu (
    .a      (rs_fwd),
    .b      (op_b),
    .op     (alu_op_e'(alu_op)),
    .result (alu_result)
  );

  // A held E slot sends a bubble to M; bubbles carry zero result and store data.
  always_comb begin
    m_d    = '0;
    m_d.ir = NOP_WORD;
    if (!e_hold) begin
      m_d.ir    = e_q.ir;
      m_d.pc    = e_q.pc;
      m_d.valid = e_q.valid;
      if (e_q.valid) begin
        m_d.alu   = alu_result;
        m_d.wdata = rt_fwd;
      end
    end
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; the async reset clears both pipeline registers at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

  assign e_ir    = e_q.ir;
  assign e_pc    = e_q.pc;
  assign e_valid = e_q.valid;
  assign m_ir    = m_q.ir;
  assign m_pc    = m_q.pc;
  assign m_alu   = m_q.alu;
  assign m_wdata = m_q.wdata;
  assign m_valid = m_q.valid;

endmodule
